fast_core_branch_unit: RTL and testbench
========================================

# fast_core_branch_unit

Early-branch-resolution block for the front end. It pairs a small single-issue execution core (`fast_core`) with a PC-indexed bimodal predictor (`branch_predictor`). The core executes simple ALU ops and resolves BEQ/BNE one cycle after issue, ahead of the main pipeline. The predictor supplies taken/not-taken guesses and is trained by the commit logic.

## Interface
- `DATA_WIDTH`, 32, register/result width.
- `NUM_REGS`, 64, physical registers addressed by 6-bit indices.
- `BP_INDEX_BITS`, 8, predictor table has 2^8 entries.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_in` in 32: MIPS-format instruction word.
- `instr_valid` in 1: issue strobe.
- `src1_index`, `src2_index`, `dest_index` in 6 each: physical register indices.
- `src1_valid`, `src2_valid` in 1 each: operand readiness.
- `is_branch`, `is_load` in 1 each: instruction class hints.
- `recovery_trigger` in 1: flush.
- `result_out` out 32; `result_valid` out 1; `result_index` out 6.
- `branch_resolved` out 1; `branch_taken` out 1.
- `pc` in 32; `predict_req` in 1.
- `prediction` out 1; `prediction_valid` out 1.
- `update_pc` in 32; `update_valid` in 1; `update_taken` in 1; `update_correct` in 1.

## Operation
- **Accept rule.** Issue is accepted when `instr_valid & src1_valid & src2_valid & !is_load & !recovery_trigger`. Otherwise the instruction is dropped with no outputs. Loads are never executed here.
- **Operands.** A = reg[`src1_index`], B = reg[`src2_index`].
- **Opcodes.** Opcode is `instr_in[31:26]`, funct is `[5:0]`, imm is `[15:0]` sign-extended.
- **Opcode 0x00, R-type** (write to `dest_index`):
  - funct 0x20 ADD: A+B.
  - funct 0x22 SUB: A−B.
  - funct 0x24 AND.
  - funct 0x25 OR.
  - funct 0x2A SLT: signed, result is 1 or 0.
  - Arithmetic wraps modulo 2^32.
- **Opcode 0x08, ADDI.** Result is A+imm. Destination is `{1'b0, instr_in[20:16]}` (the rt field); `dest_index` is ignored.
- **Opcode 0x04/0x05, BEQ/BNE.**
  - Taken = (A==B) for BEQ, (A!=B) for BNE.
  - Only when `is_branch`=1: assert `branch_resolved` with `branch_taken`.
  - A branch produces no register write.
- **Unknown opcode/funct.** Accepted but produces no outputs.
- **Register file.**
  - NUM_REGS×32, all entries reset to 0.
  - Written at the same edge that registers `result_*`.
  - Index 0 is writable (no hardwired zero).
- **Recovery.** `recovery_trigger` clears `result_valid` and `branch_resolved` on the next edge and blocks issue that cycle. Register contents are preserved.
- **Predictor table.**
  - 2-bit saturating counters indexed by `pc[BP_INDEX_BITS+1:2]`.
  - Reset value 2'b01 (weakly not-taken).
  - `prediction` = counter[1].
- **Prediction.** On `predict_req`, `prediction` and `prediction_valid` are registered and held until the next `predict_req`. `prediction_valid` clears only on reset.
- **Training.** On `update_valid`, the counter at `update_pc` index increments if `update_taken` (saturate at 3), else decrements (saturate at 0).
- **`update_correct`.** Does not alter table state; it is accepted for interface compatibility.
- **Same-cycle predict and update to the same index.** The prediction uses the pre-update counter value.

## Timing
- **Reset values:** `result_out`=0, `result_valid`=0, `result_index`=0, `branch_resolved`=0, `branch_taken`=0, `prediction`=0, `prediction_valid`=0.
- **Core latency:** one cycle. An issue accepted at edge N produces outputs visible after edge N, as one-cycle pulses. `result_out` and `result_index` hold their last values.
- **Back-to-back dependency:** an instruction issued at edge N+1 reads the value written at edge N. No bypass is needed because the write completes at edge N.
- **Predictor latency:** one cycle from `predict_req` to `prediction_valid`.
- **Update timing:** the table update takes effect at the sampling edge.
- **Reset mid-operation:** all state returns immediately to reset values, including the register file and counters.

## Structure
- **Shared package `fast_core_pkg`:**
  - Opcode constants: OP_RTYPE=0x00, OP_ADDI=0x08, OP_BEQ=0x04, OP_BNE=0x05.
  - Funct constants.
  - 2-bit counter reset constant.
- **Top `fast_core_branch_unit`** instantiates two sub-modules: `fast_core` (register file, ALU, branch compare) and `branch_predictor`. They share no signals besides `clk`/`rst_n`.

## Test plan
- **ADDI then ADD.** ADDI r2=r1+10 from reset, then ADD dest 3 = r1+r2.
  - Required: `result_valid` pulses with idx 2, val 0x0000000A.
  - Then idx 3, val 0x0000000A.
- **Equal-operand BEQ.** ADDI r4=5, ADDI r5=5, then BEQ r4,r5 with `is_branch`=1.
  - Required: `branch_resolved`=1 and `branch_taken`=1 for exactly one cycle.
  - Required: no `result_valid`.
- **Unequal-operand branches.** r11=0, r12=1.
  - BEQ r11,r12: resolved, taken=0.
  - BNE r11,r12: resolved, taken=1.
- **Gating.** Assert `recovery_trigger` in the same cycle as a valid ADD → no result. Issue with `src2_valid`=0 → no result. Issue with `is_load`=1 → no result.
- **Predictor training.**
  - Fresh PCs 0x2000–0x2010: predictions are 0 with `prediction_valid`=1.
  - Update 0x2000 taken twice → predict 1.
  - Two more taken updates saturate the counter at 3.
  - One not-taken update → still predict 1.
- **Reset mid-run.** Drop `rst_n` after training and register writes.
  - Required: all outputs 0.
  - Required: registers read 0.
  - Required: predictions return to 0.

Source files
------------

// File: rtl/fast_core_pkg.sv
// Shared constants for the early-branch-resolution core and its bimodal predictor.
package fast_core_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] BP_CTR_RESET = 2'b01;

    function automatic logic [1:0] bp_sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11)
            nxt = ctr + 2'd1;
        else if (!taken && ctr != 2'b00)
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor.sv
// PC-indexed bimodal predictor: 2-bit saturating counters, registered prediction.
module branch_predictor
    import fast_core_pkg::*;
#(
    parameter int BP_INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        predict_req,
    output logic        prediction,
    output logic        prediction_valid,
    input  logic [31:0] update_pc,
    input  logic        update_valid,
    input  logic        update_taken,
    input  logic        update_correct
);

    localparam int ENTRIES = 1 << BP_INDEX_BITS;

    logic [1:0]               ctr_q [ENTRIES];
    logic                     prediction_q,       prediction_d;
    logic                     prediction_valid_q, prediction_valid_d;
    logic [BP_INDEX_BITS-1:0] pred_idx, upd_idx;

    assign pred_idx = pc[BP_INDEX_BITS+1:2];
    assign upd_idx  = update_pc[BP_INDEX_BITS+1:2];

    // Prediction reads the counter before any same-edge training write lands.
    always_comb begin
        prediction_d       = prediction_q;
        prediction_valid_d = prediction_valid_q;
        if (predict_req) begin
            prediction_d       = ctr_q[pred_idx][1];
            prediction_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr_q[i] <= BP_CTR_RESET;
            prediction_q       <= 1'b0;
            prediction_valid_q <= 1'b0;
        end else begin
            if (update_valid)
                ctr_q[upd_idx] <= bp_sat_update(ctr_q[upd_idx], update_taken);
            prediction_q       <= prediction_d;
            prediction_valid_q <= prediction_valid_d;
        end
    end

    assign prediction       = prediction_q;
    assign prediction_valid = prediction_valid_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[31:BP_INDEX_BITS+2], pc[1:0],
                              update_pc[31:BP_INDEX_BITS+2], update_pc[1:0], update_correct};

endmodule

// File: rtl/fast_core.sv
// Single-issue ALU core: register file, ALU and BEQ/BNE compare, one-cycle result latency.
module fast_core
    import fast_core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 instr_in,
    input  logic                        instr_valid,
    input  logic [$clog2(NUM_REGS)-1:0] src1_index,
    input  logic [$clog2(NUM_REGS)-1:0] src2_index,
    input  logic [$clog2(NUM_REGS)-1:0] dest_index,
    input  logic                        src1_valid,
    input  logic                        src2_valid,
    input  logic                        is_branch,
    input  logic                        is_load,
    input  logic                        recovery_trigger,
    output logic [DATA_WIDTH-1:0]       result_out,
    output logic                        result_valid,
    output logic [$clog2(NUM_REGS)-1:0] result_index,
    output logic                        branch_resolved,
    output logic                        branch_taken
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] result_out_q,      result_out_d;
    logic [IDX_W-1:0]      result_index_q,    result_index_d;
    logic                  result_valid_q,    result_valid_d;
    logic                  branch_resolved_q, branch_resolved_d;
    logic                  branch_taken_q,    branch_taken_d;

    logic [5:0]            opcode, funct;
    logic [DATA_WIDTH-1:0] opa, opb, imm_ext;
    logic                  accept;

    assign opcode  = instr_in[31:26];
    assign funct   = instr_in[5:0];
    assign imm_ext = {{(DATA_WIDTH-16){instr_in[15]}}, instr_in[15:0]};
    assign opa     = regs_q[src1_index];
    assign opb     = regs_q[src2_index];
    assign accept  = instr_valid & src1_valid & src2_valid & ~is_load & ~recovery_trigger;

    always_comb begin
        result_valid_d    = 1'b0;
        result_out_d      = result_out_q;
        result_index_d    = result_index_q;
        branch_resolved_d = 1'b0;
        branch_taken_d    = 1'b0;
        if (accept) begin
            case (opcode)
                OP_RTYPE: begin
                    result_index_d = dest_index;
                    case (funct)
                        FN_ADD: begin result_valid_d = 1'b1; result_out_d = opa + opb; end
                        FN_SUB: begin result_valid_d = 1'b1; result_out_d = opa - opb; end
                        FN_AND: begin result_valid_d = 1'b1; result_out_d = opa & opb; end
                        FN_OR:  begin result_valid_d = 1'b1; result_out_d = opa | opb; end
                        FN_SLT: begin
                            result_valid_d = 1'b1;
                            result_out_d   = {{(DATA_WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
                        end
                        default: result_index_d = result_index_q;
                    endcase
                end
                // ADDI targets the rt field, never dest_index
                OP_ADDI: begin
                    result_valid_d = 1'b1;
                    result_out_d   = opa + imm_ext;
                    result_index_d = {{(IDX_W-5){1'b0}}, instr_in[20:16]};
                end
                OP_BEQ: begin
                    branch_resolved_d = is_branch;
                    branch_taken_d    = is_branch & (opa == opb);
                end
                OP_BNE: begin
                    branch_resolved_d = is_branch;
                    branch_taken_d    = is_branch & (opa != opb);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            result_out_q      <= '0;
            result_index_q    <= '0;
            result_valid_q    <= 1'b0;
            branch_resolved_q <= 1'b0;
            branch_taken_q    <= 1'b0;
        end else begin
            if (result_valid_d)
                regs_q[result_index_d] <= result_out_d;
            result_out_q      <= result_out_d;
            result_index_q    <= result_index_d;
            result_valid_q    <= result_valid_d;
            branch_resolved_q <= branch_resolved_d;
            branch_taken_q    <= branch_taken_d;
        end
    end

    assign result_out      = result_out_q;
    assign result_index    = result_index_q;
    assign result_valid    = result_valid_q;
    assign branch_resolved = branch_resolved_q;
    assign branch_taken    = branch_taken_q;

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_in[25:21];

endmodule

// File: rtl/fast_core_branch_unit.sv
// Early branch resolution block: independent execution core and bimodal predictor.
module fast_core_branch_unit
    import fast_core_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 64,
    parameter int BP_INDEX_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 instr_in,
    input  logic                        instr_valid,
    input  logic [$clog2(NUM_REGS)-1:0] src1_index,
    input  logic [$clog2(NUM_REGS)-1:0] src2_index,
    input  logic [$clog2(NUM_REGS)-1:0] dest_index,
    input  logic                        src1_valid,
    input  logic                        src2_valid,
    input  logic                        is_branch,
    input  logic                        is_load,
    input  logic                        recovery_trigger,
    output logic [DATA_WIDTH-1:0]       result_out,
    output logic                        result_valid,
    output logic [$clog2(NUM_REGS)-1:0] result_index,
    output logic                        branch_resolved,
    output logic                        branch_taken,
    input  logic [31:0]                 pc,
    input  logic                        predict_req,
    output logic                        prediction,
    output logic                        prediction_valid,
    input  logic [31:0]                 update_pc,
    input  logic                        update_valid,
    input  logic                        update_taken,
    input  logic                        update_correct
);

    fast_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_core (
        .clk              (clk),
        .rst_n            (rst_n),
        .instr_in         (instr_in),
        .instr_valid      (instr_valid),
        .src1_index       (src1_index),
        .src2_index       (src2_index),
        .dest_index       (dest_index),
        .src1_valid       (src1_valid),
        .src2_valid       (src2_valid),
        .is_branch        (is_branch),
        .is_load          (is_load),
        .recovery_trigger (recovery_trigger),
        .result_out       (result_out),
        .result_valid     (result_valid),
        .result_index     (result_index),
        .branch_resolved  (branch_resolved),
        .branch_taken     (branch_taken)
    );

    branch_predictor #(
        .BP_INDEX_BITS (BP_INDEX_BITS)
    ) u_bp (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc               (pc),
        .predict_req      (predict_req),
        .prediction       (prediction),
        .prediction_valid (prediction_valid),
        .update_pc        (update_pc),
        .update_valid     (update_valid),
        .update_taken     (update_taken),
        .update_correct   (update_correct)
    );

endmodule

// File: tb/tb_fast_core_branch_unit.sv
// Scoreboard bench: reference model queues expected responses, negedge monitor checks them.
module tb_fast_core_branch_unit;
    import fast_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_in = '0;
    logic        instr_valid = 1'b0;
    logic [5:0]  src1_index = '0, src2_index = '0, dest_index = '0;
    logic        src1_valid = 1'b0, src2_valid = 1'b0;
    logic        is_branch = 1'b0, is_load = 1'b0, recovery_trigger = 1'b0;
    logic [31:0] result_out;
    logic        result_valid;
    logic [5:0]  result_index;
    logic        branch_resolved, branch_taken;
    logic [31:0] pc = '0;
    logic        predict_req = 1'b0;
    logic        prediction, prediction_valid;
    logic [31:0] update_pc = '0;
    logic        update_valid = 1'b0, update_taken = 1'b0, update_correct = 1'b0;

    always #5 clk = ~clk;

    fast_core_branch_unit dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
        .src1_index(src1_index), .src2_index(src2_index), .dest_index(dest_index),
        .src1_valid(src1_valid), .src2_valid(src2_valid), .is_branch(is_branch),
        .is_load(is_load), .recovery_trigger(recovery_trigger), .result_out(result_out),
        .result_valid(result_valid), .result_index(result_index),
        .branch_resolved(branch_resolved), .branch_taken(branch_taken), .pc(pc),
        .predict_req(predict_req), .prediction(prediction), .prediction_valid(prediction_valid),
        .update_pc(update_pc), .update_valid(update_valid), .update_taken(update_taken),
        .update_correct(update_correct)
    );

    typedef struct {
        int          cyc;
        bit          is_br;
        logic [5:0]  idx;
        logic [31:0] val;
        bit          taken;
    } core_exp_t;

    typedef struct {
        int cyc;
        bit pred;
    } pred_exp_t;

    core_exp_t   cq[$];
    pred_exp_t   pq[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] m_regs [64];
    int          m_ctr [256];
    bit          hold_pred = 0, hold_valid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a core result or a prediction.
    always @(negedge clk) begin
        if (rst_n) begin
            core_exp_t ce;
            pred_exp_t pe;
            while (cq.size() > 0 && cq[0].cyc < cyc) begin
                ce = cq.pop_front();
                check("core_output_missing_cycle", cyc, ce.cyc);
            end
            if (result_valid || branch_resolved) begin
                if (cq.size() == 0) begin
                    check("core_unexpected_output", {30'd0, result_valid, branch_resolved}, 32'd0);
                end else begin
                    ce = cq.pop_front();
                    check("core_output_cycle", cyc, ce.cyc);
                    if (ce.is_br) begin
                        check("branch_resolved", branch_resolved, 1);
                        check("branch_no_result", result_valid, 0);
                        check("branch_taken", branch_taken, ce.taken);
                    end else begin
                        check("result_valid", result_valid, 1);
                        check("result_no_branch", branch_resolved, 0);
                        check("result_index", result_index, ce.idx);
                        check("result_out", result_out, ce.val);
                    end
                end
            end
            if (pq.size() > 0 && pq[0].cyc == cyc) begin
                pe = pq.pop_front();
                check("prediction", prediction, pe.pred);
                check("prediction_valid", prediction_valid, 1);
                hold_pred  = pe.pred;
                hold_valid = 1;
            end else begin
                check("prediction_hold", prediction, hold_pred);
                check("prediction_valid_hold", prediction_valid, hold_valid);
            end
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_regs[i] = '0;
        for (int i = 0; i < 256; i++) m_ctr[i] = 1;
        cq.delete();
        pq.delete();
        hold_pred  = 0;
        hold_valid = 0;
    endfunction

    // Reference model: evaluates the inputs currently driven, as the coming edge will see them.
    function automatic void model_cycle();
        core_exp_t   ce;
        logic [31:0] a, b, r;
        logic [5:0]  op;
        bit          has;
        int          pi, ui;
        if (instr_valid && src1_valid && src2_valid && !is_load && !recovery_trigger) begin
            a   = m_regs[src1_index];
            b   = m_regs[src2_index];
            op  = instr_in[31:26];
            has = 0;
            r   = '0;
            ce.cyc = cyc + 1; ce.is_br = 0; ce.idx = dest_index; ce.taken = 0;
            if (op == OP_RTYPE) begin
                has = 1;
                case (instr_in[5:0])
                    6'h20:   r = a + b;
                    6'h22:   r = a - b;
                    6'h24:   r = a & b;
                    6'h25:   r = a | b;
                    6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: has = 0;
                endcase
            end else if (op == OP_ADDI) begin
                has    = 1;
                r      = a + {{16{instr_in[15]}}, instr_in[15:0]};
                ce.idx = {1'b0, instr_in[20:16]};
            end else if ((op == OP_BEQ || op == OP_BNE) && is_branch) begin
                ce.is_br = 1;
                ce.taken = (op == OP_BEQ) ? (a == b) : (a != b);
                ce.val   = '0;
                cq.push_back(ce);
            end
            if (has) begin
                ce.val = r;
                m_regs[ce.idx] = r;
                cq.push_back(ce);
            end
        end
        pi = int'(pc[9:2]);
        ui = int'(update_pc[9:2]);
        if (predict_req) begin
            pred_exp_t pe;
            pe.cyc  = cyc + 1;
            pe.pred = (m_ctr[pi] >= 2);
            pq.push_back(pe);
        end
        if (update_valid) begin
            if (update_taken) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
            else              m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
        end
    endfunction

    task automatic tick();
        model_cycle();
        @(posedge clk);
        #1;
        instr_valid = 0; src1_valid = 0; src2_valid = 0; is_branch = 0; is_load = 0;
        recovery_trigger = 0; predict_req = 0; update_valid = 0; update_taken = 0;
        update_correct = 0;
    endtask

    task automatic set_core(input logic [31:0] ins, input int s1, input int s2, input int d,
                            input bit br);
        instr_in = ins; instr_valid = 1; src1_valid = 1; src2_valid = 1;
        src1_index = 6'(s1); src2_index = 6'(s2); dest_index = 6'(d); is_branch = br;
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {OP_RTYPE, 20'h0, fn};
    endfunction

    function automatic logic [31:0] addi(input int rt, input logic [15:0] imm);
        return {OP_ADDI, 5'd0, 5'(rt), imm};
    endfunction

    task automatic predict(input logic [31:0] p);
        pc = p; predict_req = 1; tick();
    endtask

    task automatic train(input logic [31:0] p, input bit tk);
        update_pc = p; update_valid = 1; update_taken = tk; update_correct = $urandom_range(0, 1); tick();
    endtask

    task automatic check_reset_outputs();
        check("rst_result_out", result_out, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_index", result_index, 0);
        check("rst_branch_resolved", branch_resolved, 0);
        check("rst_branch_taken", branch_taken, 0);
        check("rst_prediction", prediction, 0);
        check("rst_prediction_valid", prediction_valid, 0);
    endtask

    initial begin
        logic [5:0] fn_tab [6];
        logic [5:0] op_tab [5];
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
        op_tab = '{6'h00, 6'h08, 6'h04, 6'h05, 6'h0C};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1;
        tick();

        // ADDI r2 = r1 + 10, then ADD r3 = r1 + r2
        set_core(addi(2, 16'd10), 1, 0, 63, 0); tick();
        set_core(rtype(FN_ADD), 1, 2, 3, 0);    tick();

        // equal-operand BEQ
        set_core(addi(4, 16'd5), 0, 0, 0, 0);   tick();
        set_core(addi(5, 16'd5), 0, 0, 0, 0);   tick();
        set_core({OP_BEQ, 26'h0}, 4, 5, 0, 1);  tick();
        tick();

        // unequal operands; also a BEQ without the branch hint
        set_core(addi(11, 16'd0), 0, 0, 0, 0);  tick();
        set_core(addi(12, 16'd1), 0, 0, 0, 0);  tick();
        set_core({OP_BEQ, 26'h0}, 11, 12, 0, 1); tick();
        set_core({OP_BNE, 26'h0}, 11, 12, 0, 1); tick();
        set_core({OP_BNE, 26'h0}, 11, 12, 0, 0); tick();

        // SLT signed boundary and SUB wrap
        set_core(addi(13, 16'hFFFF), 0, 0, 0, 0); tick();
        set_core(rtype(FN_SLT), 13, 12, 14, 0);   tick();
        set_core(rtype(FN_SLT), 12, 13, 15, 0);   tick();
        set_core(rtype(FN_SUB), 0, 12, 16, 0);    tick();

        // gating
        set_core(rtype(FN_ADD), 1, 2, 7, 0); recovery_trigger = 1; tick();
        set_core(rtype(FN_ADD), 1, 2, 7, 0); src2_valid = 0;       tick();
        set_core(rtype(FN_ADD), 1, 2, 7, 0); is_load = 1;          tick();
        set_core(rtype(6'h3F), 1, 2, 7, 0);                        tick();
        tick();

        // predictor training
        for (int i = 0; i < 5; i++) predict(32'h2000 + 32'(i * 4));
        train(32'h2000, 1); train(32'h2000, 1);
        predict(32'h2000);
        train(32'h2000, 1); train(32'h2000, 1);
        train(32'h2000, 0);
        predict(32'h2000);
        train(32'h2000, 0);
        predict(32'h2000);
        train(32'h2004, 0); train(32'h2004, 0); train(32'h2004, 1);
        predict(32'h2004);
        // same-cycle predict/update to one index sees the old counter
        train(32'h2008, 1);
        pc = 32'h2008; predict_req = 1; update_pc = 32'hFFFF_2008; update_valid = 1; update_taken = 1; tick();
        predict(32'h2008);

        // randomized mixed traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                logic [31:0] ins;
                logic [5:0]  op;
                ins = $urandom;
                op  = op_tab[$urandom_range(0, 4)];
                ins[31:26] = op;
                if (op == OP_RTYPE) ins[5:0] = fn_tab[$urandom_range(0, 5)];
                set_core(ins, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 63),
                         $urandom_range(0, 4) != 0);
                src1_valid       = ($urandom_range(0, 7) != 0);
                src2_valid       = ($urandom_range(0, 7) != 0);
                is_load          = ($urandom_range(0, 9) == 0);
                recovery_trigger = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 2) == 0) begin
                predict_req = 1;
                pc = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
            end
            if ($urandom_range(0, 1) == 0) begin
                update_valid   = 1;
                update_taken   = $urandom_range(0, 1);
                update_correct = $urandom_range(0, 1);
                update_pc = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
            end
            tick();
        end
        tick(); tick();

        // reset mid-run after training and register writes
        set_core(addi(20, 16'h1234), 0, 0, 0, 0); tick();
        train(32'h2000, 1); train(32'h2000, 1);
        tick(); tick();
        check("queue_drained_before_reset", cq.size() + pq.size(), 0);
        rst_n = 0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        tick();
        set_core(rtype(FN_OR), 20, 2, 21, 0); tick();
        set_core(addi(22, 16'd0), 4, 0, 0, 0); tick();
        set_core({OP_BNE, 26'h0}, 5, 0, 0, 1); tick();
        predict(32'h2000);
        tick(); tick();

        check("scoreboard_empty", cq.size() + pq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
